zadan_div: RTL and testbench



---
 rtl/zadan_div.sv | 139 +++++++++++++
 tb/tb_zadan_div.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zadan_div.sv
// zadan_div: sequential unsigned restoring divider, 2N-bit dividend by
// N-bit divisor, producing one quotient bit per clock.
// Ports:
//   clk, reset            - clock, async active-high reset
//   start                 - begin a division (sampled only in IDLE)
//   dividend [2N-1:0]     - unsigned dividend, captured on accepted start
//   divisor  [N-1:0]      - unsigned divisor, captured on accepted start
//   quotient [2N-1:0]     - registered quotient, held until next result
//   remainder[N-1:0]      - registered remainder, held until next result
//   busy                  - high while iterating
//   done                  - one-cycle result-valid pulse
//   div_by_zero           - captured divisor was zero
//   q_overflow            - quotient does not fit in N bits
module zadan_div #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           busy,
    output logic           done,
    output logic           div_by_zero,
    output logic           q_overflow
);

    localparam int CW = $clog2(2*N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t state;
    state_t state_n;

    logic [2*N-1:0] d_reg;
    logic [N-1:0]   dv_reg;
    // After every step P < divisor, so the stored partial remainder fits
    // in N bits; the extra carry bit lives only in the shifted value P'.
    logic [N-1:0]   p_reg;
    logic [CW-1:0]  cnt;

    logic [N:0]     p_sh;
    logic           ge;
    logic [N:0]     p_next;
    logic [2*N-1:0] d_next;

    // One restoring step: shift in the next dividend bit, trial subtract.
    always_comb begin
        p_sh   = {p_reg, d_reg[2*N-1]};
        ge     = (p_sh >= {1'b0, dv_reg});
        p_next = ge ? (p_sh - {1'b0, dv_reg}) : p_sh;
        d_next = {d_reg[2*N-2:0], ge};
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = (divisor == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt == '0) begin
                    state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Status outputs decode the registered state only
    always_comb begin
        busy = (state == S_CALC);
        done = (state == S_DONE);
    end

    // Datapath and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_reg       <= '0;
            dv_reg      <= '0;
            p_reg       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            q_overflow  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend[N-1:0];
                            div_by_zero <= 1'b1;
                            q_overflow  <= 1'b0;
                        end else begin
                            d_reg  <= dividend;
                            dv_reg <= divisor;
                            p_reg  <= '0;
                            cnt    <= CW'(2*N-1);
                        end
                    end
                end
                S_CALC: begin
                    d_reg <= d_next;
                    p_reg <= p_next[N-1:0];
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) begin
                        quotient    <= d_next;
                        remainder   <= p_next[N-1:0];
                        q_overflow  <= |d_next[2*N-1:N];
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_zadan_div.sv
// tb_zadan_div: directed self-checking bench for zadan_div (N=8).
// Each task drives one scenario and checks its results inline.
module tb_zadan_div;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic        q_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    zadan_div #(.N(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .q_overflow (q_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands with start for one rising edge; returns at the
    // falling edge right after the accepting edge.
    task automatic do_start(input logic [15:0] dd, input logic [7:0] dv);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Counts falling edges (one per elapsed clock) until done is seen,
    // and how many of those cycles had busy high. Bounded at 100.
    task automatic wait_done(output int cyc, output int bc);
        cyc = 0;
        bc  = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        #2;
        n_checks++;
        if (quotient !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_q: got %0d want 0", quotient);
        end
        n_checks++;
        if (remainder !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_r: got %0d want 0", remainder);
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_bd: got %b%b want 00", busy, done);
        end
        n_checks++;
        if (div_by_zero !== 1'b0 || q_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_flags: got %b%b want 00",
                     div_by_zero, q_overflow);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_bd: got %b%b want 00", busy, done);
        end
    endtask

    task automatic test_basic;
        int cyc;
        int bc;
        do_start(16'd1000, 8'd7);
        dividend = 16'hFFFF;
        divisor  = 8'd3;
        wait_done(cyc, bc);
        n_checks++;
        if (cyc !== 16) begin
            n_fail++;
            $display("FAIL basic_lat: got %0d want 16", cyc);
        end
        n_checks++;
        if (bc !== 16) begin
            n_fail++;
            $display("FAIL basic_busy: got %0d want 16", bc);
        end
        n_checks++;
        if (quotient !== 16'd142 || remainder !== 8'd6) begin
            n_fail++;
            $display("FAIL basic_qr: got %0d r %0d want 142 r 6",
                     quotient, remainder);
        end
        n_checks++;
        if (q_overflow !== 1'b0 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_flags: got %b%b want 00",
                     q_overflow, div_by_zero);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || quotient !== 16'd142) begin
            n_fail++;
            $display("FAIL basic_hold: got done=%b q=%0d want 0 142",
                     done, quotient);
        end
    endtask

    task automatic test_inverse;
        int cyc;
        int bc;
        do_start(16'd65025, 8'd255);
        wait_done(cyc, bc);
        n_checks++;
        if (quotient !== 16'd255 || remainder !== 8'd0) begin
            n_fail++;
            $display("FAIL inv_max: got %0d r %0d want 255 r 0",
                     quotient, remainder);
        end
        n_checks++;
        if (q_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_ovf: got %b want 0", q_overflow);
        end
        do_start(16'd12345, 8'd255);
        wait_done(cyc, bc);
        n_checks++;
        if (quotient !== 16'd48 || remainder !== 8'd105) begin
            n_fail++;
            $display("FAIL inv_12345: got %0d r %0d want 48 r 105",
                     quotient, remainder);
        end
    endtask

    task automatic test_overflow;
        int cyc;
        int bc;
        do_start(16'd65535, 8'd1);
        wait_done(cyc, bc);
        n_checks++;
        if (quotient !== 16'd65535 || remainder !== 8'd0) begin
            n_fail++;
            $display("FAIL ovf_qr: got %0d r %0d want 65535 r 0",
                     quotient, remainder);
        end
        n_checks++;
        if (q_overflow !== 1'b1 || div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_flags: got %b%b want 10",
                     q_overflow, div_by_zero);
        end
    endtask

    task automatic test_div_zero;
        int cyc;
        int bc;
        do_start(16'd200, 8'd0);
        wait_done(cyc, bc);
        n_checks++;
        if (cyc !== 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL dz_lat: got cyc=%0d busy=%b want 0 0",
                     cyc, busy);
        end
        n_checks++;
        if (quotient !== 16'd65535 || remainder !== 8'd200) begin
            n_fail++;
            $display("FAIL dz_qr: got %0d r %0d want 65535 r 200",
                     quotient, remainder);
        end
        n_checks++;
        if (div_by_zero !== 1'b1 || q_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL dz_flags: got %b%b want 10",
                     div_by_zero, q_overflow);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL dz_after: got d=%b b=%b z=%b want 0 0 1",
                     done, busy, div_by_zero);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        int bc;
        @(negedge clk);
        dividend = 16'd0;
        divisor  = 8'd5;
        start    = 1'b1;
        @(negedge clk);
        dividend = 16'd1000;
        divisor  = 8'd7;
        wait_done(cyc, bc);
        n_checks++;
        if (cyc !== 16) begin
            n_fail++;
            $display("FAIL b2b_lat: got %0d want 16", cyc);
        end
        n_checks++;
        if (quotient !== 16'd0 || remainder !== 8'd0) begin
            n_fail++;
            $display("FAIL b2b_first: got %0d r %0d want 0 r 0",
                     quotient, remainder);
        end
        n_checks++;
        if (div_by_zero !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done_st: got z=%b b=%b want 0 0",
                     div_by_zero, busy);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got b=%b d=%b want 0 0", busy, done);
        end
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%b want 1", busy);
        end
        wait_done(cyc, bc);
        n_checks++;
        if (quotient !== 16'd142 || remainder !== 8'd6 || cyc !== 16) begin
            n_fail++;
            $display("FAIL b2b_second: got %0d r %0d cyc %0d want 142 r 6 16",
                     quotient, remainder, cyc);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_single: got b=%b d=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        int bc;
        do_start(16'd1000, 8'd7);
        repeat (7) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (quotient !== 16'd0 || remainder !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_qr: got %0d r %0d want 0 r 0",
                     quotient, remainder);
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_bd: got %b%b want 00", busy, done);
        end
        n_checks++;
        if (div_by_zero !== 1'b0 || q_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_flags: got %b%b want 00",
                     div_by_zero, q_overflow);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_idle: got %b%b want 00", busy, done);
        end
        do_start(16'd1000, 8'd7);
        wait_done(cyc, bc);
        n_checks++;
        if (quotient !== 16'd142 || remainder !== 8'd6 || cyc !== 16) begin
            n_fail++;
            $display("FAIL mid_redo: got %0d r %0d cyc %0d want 142 r 6 16",
                     quotient, remainder, cyc);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        test_reset;
        test_basic;
        test_inverse;
        test_overflow;
        test_div_zero;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
